// File: rtl/tag_match_pkg.sv
// Shared constants and types for the pipelined tag-match priority encoder.
//   TM_RADIX     : fan-in of a full reduction level
//   TM_MAX_WAYS  : largest supported hit-vector width
//   tm_node_t    : per-node reduction result {valid, multi, index}, sized
//                  for the largest configuration
//   tm_levels(n) : number of reduction levels (= latency) for n ways
package tag_match_pkg;

    localparam int TM_RADIX     = 4;
    localparam int TM_MAX_WAYS  = 4096;
    localparam int TM_MAX_BIN_W = $clog2(TM_MAX_WAYS);

    typedef struct packed {
        logic                    valid;
        logic                    multi;
        logic [TM_MAX_BIN_W-1:0] index;
    } tm_node_t;

    // Each level retires two index bits; an odd index width costs one
    // extra radix-2 level at the leaves.
    function automatic int tm_levels(input int n);
        return ($clog2(n) + 1) / 2;
    endfunction

endpackage

// File: rtl/tag_match_pe4_stage.sv
// One reduction level of the tag-match encoder: a radix-4 (or radix-2)
// lowest-index-wins combine followed by a valid/ready register slice.
//   in_valid/in_ready   : upstream handshake
//   in_hit/in_idx       : child results (in_idx ignored at the leaf level)
//   in_multi            : child multi-hit flags (TAG_MATCH_MULTIHIT_EN only)
//   in_id               : sideband request ID
//   out_valid/out_ready : downstream handshake
//   out_hit/out_idx     : combined results, child number prepended as MSBs
//   out_multi           : combined multi-hit flags (TAG_MATCH_MULTIHIT_EN only)
//   out_id              : registered request ID
// Optional feature macro: TAG_MATCH_MULTIHIT_EN.
module tag_match_pe4_stage
    import tag_match_pkg::*;
#(
    parameter int IN_NODES  = 1024,
    parameter int RADIX_LOG = 2,
    parameter int IN_IDX_W  = 0,
    parameter int ID_W      = 4,
    localparam int RADIX     = (RADIX_LOG == 2) ? TM_RADIX : 2,
    localparam int IN_IDX_PW = (IN_IDX_W > 0) ? IN_IDX_W : 1,
    localparam int OUT_NODES = IN_NODES >> RADIX_LOG,
    localparam int OUT_IDX_W = IN_IDX_W + RADIX_LOG
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [IN_NODES-1:0]                   in_hit,
    input  logic [IN_NODES-1:0][IN_IDX_PW-1:0]    in_idx,
`ifdef TAG_MATCH_MULTIHIT_EN
    input  logic [IN_NODES-1:0]                   in_multi,
    output logic [OUT_NODES-1:0]                  out_multi,
`endif
    input  logic [ID_W-1:0]                       in_id,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_NODES-1:0]                  out_hit,
    output logic [OUT_NODES-1:0][OUT_IDX_W-1:0]   out_idx,
    output logic [ID_W-1:0]                       out_id
);

    logic [OUT_NODES-1:0]                 hit_c;
    logic [OUT_NODES-1:0][RADIX_LOG-1:0]  sel_c;
    logic [OUT_NODES-1:0][OUT_IDX_W-1:0]  idx_c;

    // Scan children from the top down so the lowest hitting child wins.
    // A node with no hit selects child 0, whose index is itself zero, so an
    // all-zero vector reduces to index 0.
    always_comb begin
        hit_c = '0;
        sel_c = '0;
        for (int j = 0; j < OUT_NODES; j++) begin
            for (int c = RADIX - 1; c >= 0; c--) begin
                if (in_hit[j*RADIX + c]) begin
                    hit_c[j] = 1'b1;
                    sel_c[j] = RADIX_LOG'(c);
                end
            end
        end
    end

    if (IN_IDX_W == 0) begin : g_leaf
        logic unused_idx;
        assign unused_idx = ^in_idx;
        assign idx_c      = sel_c;
    end else begin : g_node
        always_comb begin
            idx_c = '0;
            for (int j = 0; j < OUT_NODES; j++) begin
                for (int c = 0; c < RADIX; c++) begin
                    if (sel_c[j] == RADIX_LOG'(c)) begin
                        idx_c[j] = {sel_c[j], in_idx[j*RADIX + c]};
                    end
                end
            end
        end
    end

`ifdef TAG_MATCH_MULTIHIT_EN
    logic [OUT_NODES-1:0] multi_c;
    logic [2:0]           n_hit;

    // Multiple hits either came up from below or meet here for the first time.
    always_comb begin
        multi_c = '0;
        n_hit   = '0;
        for (int j = 0; j < OUT_NODES; j++) begin
            n_hit = '0;
            for (int c = 0; c < RADIX; c++) begin
                if (in_hit[j*RADIX + c]) begin
                    n_hit = n_hit + 3'd1;
                end
                if (in_multi[j*RADIX + c]) begin
                    multi_c[j] = 1'b1;
                end
            end
            if (n_hit >= 3'd2) begin
                multi_c[j] = 1'b1;
            end
        end
    end
`endif

    // Register slice
    logic                                 valid_q, valid_d;
    logic [OUT_NODES-1:0]                 hit_q, hit_d;
    logic [OUT_NODES-1:0][OUT_IDX_W-1:0]  idx_q, idx_d;
    logic [ID_W-1:0]                      id_q, id_d;
`ifdef TAG_MATCH_MULTIHIT_EN
    logic [OUT_NODES-1:0]                 multi_q, multi_d;
`endif

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = in_ready ? in_valid : valid_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        id_d    = id_q;
`ifdef TAG_MATCH_MULTIHIT_EN
        multi_d = multi_q;
`endif
        // Payload only moves on a real transfer, so a stalled slice holds.
        if (in_valid && in_ready) begin
            hit_d   = hit_c;
            idx_d   = idx_c;
            id_d    = in_id;
`ifdef TAG_MATCH_MULTIHIT_EN
            multi_d = multi_c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            hit_q   <= '0;
            idx_q   <= '0;
            id_q    <= '0;
`ifdef TAG_MATCH_MULTIHIT_EN
            multi_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
`ifdef TAG_MATCH_MULTIHIT_EN
            multi_q <= multi_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_hit   = hit_q;
    assign out_idx   = idx_q;
    assign out_id    = id_q;
`ifdef TAG_MATCH_MULTIHIT_EN
    assign out_multi = multi_q;
`endif

endmodule

// File: rtl/tag_match_encoder_pipe.sv
// Pipelined lowest-index-wins tag-match encoder. Reduces an N_WAYS hit
// vector to {bin, vld} over LEVELS register stages (one radix-4 level each,
// radix-2 at the leaves when the index width is odd).
//   clk, rst (async, active low)
//   in_valid/in_ready, oht, in_id      : request side
//   out_valid/out_ready, bin, vld,
//   multi, out_id                      : result side
// Optional feature macro: TAG_MATCH_MULTIHIT_EN adds the multi output
// (two or more ways hit) and its per-stage state.
module tag_match_encoder_pipe
    import tag_match_pkg::*;
#(
    parameter int N_WAYS = 1024,
    parameter int ID_W   = 4,
    parameter int BIN_W  = $clog2(N_WAYS),
    parameter int LEVELS = tm_levels(N_WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_WAYS-1:0] oht,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  bin,
    output logic              vld,
`ifdef TAG_MATCH_MULTIHIT_EN
    output logic              multi,
`endif
    output logic [ID_W-1:0]   out_id
);

    localparam int R0_LOG = (BIN_W % 2 == 1) ? 1 : 2;

    // vld_pipe[k]/rdy_pipe[k]: handshake into stage k; index LEVELS is the
    // output port pair.
    logic [LEVELS:0] vld_pipe;
    logic [LEVELS:0] rdy_pipe;

    // Holds the input closed until the first clock edge after reset.
    logic init_q, init_d;

    always_comb begin
        init_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end

    assign vld_pipe[0]      = in_valid && init_q;
    assign in_ready         = rdy_pipe[0] && init_q;
    assign rdy_pipe[LEVELS] = out_ready;
    assign out_valid        = vld_pipe[LEVELS];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int RLOG      = (k == 0) ? R0_LOG : 2;
        localparam int IDX_IN_W  = (k == 0) ? 0 : R0_LOG + 2*(k-1);
        localparam int IDX_IN_PW = (IDX_IN_W > 0) ? IDX_IN_W : 1;
        localparam int IDX_OUT_W = IDX_IN_W + RLOG;
        localparam int NODES_IN  = N_WAYS >> IDX_IN_W;
        localparam int NODES_OUT = N_WAYS >> IDX_OUT_W;

        logic [NODES_IN-1:0]                  hit_in;
        logic [NODES_IN-1:0][IDX_IN_PW-1:0]   idx_in;
        logic [ID_W-1:0]                      id_in;
        logic [NODES_OUT-1:0]                 hit;
        logic [NODES_OUT-1:0][IDX_OUT_W-1:0]  idx;
        logic [ID_W-1:0]                      id;
`ifdef TAG_MATCH_MULTIHIT_EN
        logic [NODES_IN-1:0]                  multi_in;
        logic [NODES_OUT-1:0]                 multi;
`endif

        if (k == 0) begin : g_src
            assign hit_in   = oht;
            assign idx_in   = '0;
            assign id_in    = in_id;
`ifdef TAG_MATCH_MULTIHIT_EN
            assign multi_in = '0;
`endif
        end else begin : g_src
            assign hit_in   = g_lvl[k-1].hit;
            assign idx_in   = g_lvl[k-1].idx;
            assign id_in    = g_lvl[k-1].id;
`ifdef TAG_MATCH_MULTIHIT_EN
            assign multi_in = g_lvl[k-1].multi;
`endif
        end

        tag_match_pe4_stage #(
            .IN_NODES  (NODES_IN),
            .RADIX_LOG (RLOG),
            .IN_IDX_W  (IDX_IN_W),
            .ID_W      (ID_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld_pipe[k]),
            .in_ready  (rdy_pipe[k]),
            .in_hit    (hit_in),
            .in_idx    (idx_in),
`ifdef TAG_MATCH_MULTIHIT_EN
            .in_multi  (multi_in),
            .out_multi (multi),
`endif
            .in_id     (id_in),
            .out_valid (vld_pipe[k+1]),
            .out_ready (rdy_pipe[k+1]),
            .out_hit   (hit),
            .out_idx   (idx),
            .out_id    (id)
        );
    end

    assign bin    = g_lvl[LEVELS-1].idx[0];
    assign vld    = g_lvl[LEVELS-1].hit[0];
    assign out_id = g_lvl[LEVELS-1].id;
`ifdef TAG_MATCH_MULTIHIT_EN
    assign multi  = g_lvl[LEVELS-1].multi[0];
`endif

endmodule

// File: tb/tb_tag_match_encoder_pipe.sv
module tb_tag_match_encoder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 1024-way instance
    logic          m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_vld;
    logic [1023:0] m_oht;
    logic [3:0]    m_in_id, m_out_id;
    logic [9:0]    m_bin;
    // 512-way instance
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_vld;
    logic [511:0]  b_oht;
    logic [3:0]    b_in_id, b_out_id;
    logic [8:0]    b_bin;
    // 16-way instance
    logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_vld;
    logic [15:0]   c_oht;
    logic [3:0]    c_in_id, c_out_id;
    logic [3:0]    c_bin;
`ifdef TAG_MATCH_MULTIHIT_EN
    logic          m_multi, b_multi, c_multi;
`endif

    tag_match_encoder_pipe #(.N_WAYS(1024), .ID_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .oht(m_oht), .in_id(m_in_id), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .bin(m_bin), .vld(m_vld),
`ifdef TAG_MATCH_MULTIHIT_EN
        .multi(m_multi),
`endif
        .out_id(m_out_id));

    tag_match_encoder_pipe #(.N_WAYS(512), .ID_W(4)) u_dut512 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .oht(b_oht), .in_id(b_in_id), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bin(b_bin), .vld(b_vld),
`ifdef TAG_MATCH_MULTIHIT_EN
        .multi(b_multi),
`endif
        .out_id(b_out_id));

    tag_match_encoder_pipe #(.N_WAYS(16), .ID_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .oht(c_oht), .in_id(c_in_id), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .bin(c_bin), .vld(c_vld),
`ifdef TAG_MATCH_MULTIHIT_EN
        .multi(c_multi),
`endif
        .out_id(c_out_id));

    // Present one vector to the 1024-way DUT and wait for its result.
    task automatic send_one(input logic [1023:0] v, input logic [3:0] id,
                            output int lat, output logic [9:0] b, output logic h,
                            output logic mh, output logic [3:0] oid);
        @(negedge clk);
        m_oht = v; m_in_id = id; m_in_valid = 1'b1; m_out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            m_in_valid = 1'b0;
            lat++;
        end while (!m_out_valid && lat < 20);
        b = m_bin; h = m_vld; oid = m_out_id;
`ifdef TAG_MATCH_MULTIHIT_EN
        mh = m_multi;
`else
        mh = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", m_out_valid); end
        checks++; if (m_bin !== 10'd0) begin failures++; $display("FAIL rst_bin got=%0d exp=0", m_bin); end
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", m_vld); end
        checks++; if (m_out_id !== 4'd0) begin failures++; $display("FAIL rst_out_id got=%0d exp=0", m_out_id); end
        checks++; if (m_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", m_in_ready); end
`ifdef TAG_MATCH_MULTIHIT_EN
        checks++; if (m_multi !== 1'b0) begin failures++; $display("FAIL rst_multi got=%b exp=0", m_multi); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", m_in_ready); end
    endtask

    task automatic test_priority();
        int         pa[7]   = '{700,   5,  -1,  -1, 1023, 513, 3};
        int         pb[7]   = '{ -1, 900,  -1,  -1,   -1, 512, -1};
        logic       ones[7] = '{  0,   0,   0,   1,    0,   0, 0};
        logic [3:0] ids[7]  = '{  3,   5,   9,  15,    1,   2, 6};
        logic [9:0] eb[7]   = '{700,   5,   0,   0, 1023, 512, 3};
        logic       ev[7]   = '{  1,   1,   0,   1,    1,   1, 1};
        logic       em[7]   = '{  0,   1,   0,   1,    0,   1, 0};
        logic [1023:0] v;
        int lat;
        logic [9:0] b;
        logic h, mh;
        logic [3:0] oid;
        for (int t = 0; t < 7; t++) begin
            v = ones[t] ? {1024{1'b1}} : '0;
            if (pa[t] >= 0) v[pa[t]] = 1'b1;
            if (pb[t] >= 0) v[pb[t]] = 1'b1;
            send_one(v, ids[t], lat, b, h, mh, oid);
            checks++; if (lat != 5) begin failures++; $display("FAIL prio%0d_latency got=%0d exp=5", t, lat); end
            checks++; if (b !== eb[t]) begin failures++; $display("FAIL prio%0d_bin got=%0d exp=%0d", t, b, eb[t]); end
            checks++; if (h !== ev[t]) begin failures++; $display("FAIL prio%0d_vld got=%b exp=%b", t, h, ev[t]); end
            checks++; if (oid !== ids[t]) begin failures++; $display("FAIL prio%0d_out_id got=%0d exp=%0d", t, oid, ids[t]); end
`ifdef TAG_MATCH_MULTIHIT_EN
            checks++; if (mh !== em[t]) begin failures++; $display("FAIL prio%0d_multi got=%b exp=%b", t, mh, em[t]); end
`else
            if (em[t] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_back_to_back();
        int i = 0, occ = 0, ndel = 0, max_occ = 0;
        logic acc, del, stalled = 1'b0;
        logic [9:0] got_bin[8];
        logic [3:0] got_id[8];
        for (int cyc = 0; cyc < 40 && ndel < 8; cyc++) begin
            @(negedge clk);
            m_out_ready = !(cyc >= 2 && cyc <= 9);
            if (i < 8) begin
                m_in_valid = 1'b1; m_oht = '0; m_oht[i] = 1'b1; m_in_id = 4'(i);
            end else begin
                m_in_valid = 1'b0;
            end
            #1;
            checks++;
            if (m_in_ready !== (m_out_ready || occ < 5)) begin
                failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b occ=%0d", cyc, m_in_ready, (m_out_ready || occ < 5), occ);
            end
            if (!m_in_ready) stalled = 1'b1;
            acc = m_in_valid && m_in_ready;
            del = m_out_valid && m_out_ready;
            if (del && ndel < 8) begin
                got_bin[ndel] = m_bin; got_id[ndel] = m_out_id;
            end
            if (del) ndel++;
            if (acc) i++;
            occ = occ + int'(acc) - int'(del);
            if (occ > max_occ) max_occ = occ;
        end
        m_in_valid = 1'b0;
        checks++; if (!stalled) begin failures++; $display("FAIL b2b_stall got=no_stall exp=stall"); end
        checks++; if (max_occ != 5) begin failures++; $display("FAIL b2b_max_occupancy got=%0d exp=5", max_occ); end
        checks++; if (ndel != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", ndel); end
        for (int k = 0; k < 8 && k < ndel; k++) begin
            checks++; if (got_bin[k] !== 10'(k)) begin failures++; $display("FAIL b2b_bin%0d got=%0d exp=%0d", k, got_bin[k], k); end
            checks++; if (got_id[k] !== 4'(k)) begin failures++; $display("FAIL b2b_id%0d got=%0d exp=%0d", k, got_id[k], k); end
        end
        repeat (3) begin
            @(negedge clk);
            checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra_output got=%b exp=0", m_out_valid); end
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0, lat;
        logic [9:0] b;
        logic h, mh;
        logic [3:0] oid;
        logic [1023:0] v;
        m_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_in_valid = 1'b1; m_oht = '0; m_oht[100+k] = 1'b1; m_in_id = 4'(k+1);
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_bin !== 10'd100) begin failures++; $display("FAIL midrst_pre got=%b/%0d exp=1/100", m_out_valid, m_bin); end
        #2 rst = 1'b0;
        #1;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", m_out_valid); end
        checks++; if (m_bin !== 10'd0) begin failures++; $display("FAIL midrst_bin got=%0d exp=0", m_bin); end
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL midrst_vld got=%b exp=0", m_vld); end
        checks++; if (m_out_id !== 4'd0) begin failures++; $display("FAIL midrst_out_id got=%0d exp=0", m_out_id); end
        @(negedge clk);
        rst = 1'b1;
        m_out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", m_in_ready); end
        repeat (10) begin
            @(negedge clk);
            if (m_out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
        v = '0; v[42] = 1'b1;
        send_one(v, 4'd12, lat, b, h, mh, oid);
        checks++; if (lat != 5 || b !== 10'd42 || oid !== 4'd12) begin failures++; $display("FAIL midrst_after got=lat%0d/%0d/%0d exp=lat5/42/12", lat, b, oid); end
    endtask

    task automatic test_n512();
        int lat = 0;
        @(negedge clk);
        b_oht = '0; b_oht[511] = 1'b1; b_in_id = 4'd7; b_in_valid = 1'b1;
        do begin
            @(negedge clk);
            b_in_valid = 1'b0;
            lat++;
        end while (!b_out_valid && lat < 20);
        checks++; if (lat != 5) begin failures++; $display("FAIL n512_latency got=%0d exp=5", lat); end
        checks++; if (b_bin !== 9'd511) begin failures++; $display("FAIL n512_bin got=%0d exp=511", b_bin); end
        checks++; if (b_vld !== 1'b1 || b_out_id !== 4'd7) begin failures++; $display("FAIL n512_vld_id got=%b/%0d exp=1/7", b_vld, b_out_id); end
`ifdef TAG_MATCH_MULTIHIT_EN
        checks++; if (b_multi !== 1'b0) begin failures++; $display("FAIL n512_multi got=%b exp=0", b_multi); end
`endif
        @(negedge clk);
    endtask

    task automatic test_n16();
        int lat = 0;
        @(negedge clk);
        c_oht = 16'h1008; c_in_id = 4'd10; c_in_valid = 1'b1;
        do begin
            @(negedge clk);
            c_in_valid = 1'b0;
            lat++;
        end while (!c_out_valid && lat < 20);
        checks++; if (lat != 2) begin failures++; $display("FAIL n16_latency got=%0d exp=2", lat); end
        checks++; if (c_bin !== 4'd3) begin failures++; $display("FAIL n16_bin got=%0d exp=3", c_bin); end
        checks++; if (c_vld !== 1'b1 || c_out_id !== 4'd10) begin failures++; $display("FAIL n16_vld_id got=%b/%0d exp=1/10", c_vld, c_out_id); end
`ifdef TAG_MATCH_MULTIHIT_EN
        checks++; if (c_multi !== 1'b1) begin failures++; $display("FAIL n16_multi got=%b exp=1", c_multi); end
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        m_in_valid = 1'b0; m_out_ready = 1'b1; m_oht = '0; m_in_id = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_oht = '0; b_in_id = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_oht = '0; c_in_id = '0;
        test_reset();
        test_priority();
        test_back_to_back();
        test_reset_midflight();
        test_n512();
        test_n16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tag_match_encoder_pipe.md
# tag_match_encoder_pipe

Parametrised, pipelined, true-priority successor to the combinational 1024-way tag-match encoder. It converts the N-bit per-way hit vector from the fully associative cache tag compare into the lowest-index hit way plus a hit flag. It can also flag multiple simultaneous hits. One radix-4 reduction level sits per pipeline stage, with a valid/ready handshake on both sides and a sideband request ID carried alongside. It sits between the tag comparator array and the cache controller's hit/replacement logic.

## Interface
Parameters:
- N_WAYS, 1024: hit-vector width. Power of two, 4..4096.
- ID_W, 4: width of the sideband request ID passed through unchanged.
- BIN_W, $clog2(N_WAYS): width of the way index. Derived; do not override.
- LEVELS, (BIN_W+1)/2: number of reduction levels, which equals the latency in cycles. Derived.

Ports:
- clk, input, 1: the block's single clock.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: the hit vector and ID are presented this cycle.
- in_ready, output, 1: stage 0 accepts this cycle.
- oht, input, N_WAYS: per-way tag-match vector. Bit i set means way i hit.
- in_id, input, ID_W: request ID.
- out_valid, output, 1: the result is valid.
- out_ready, input, 1: the consumer accepts the result.
- bin, output, BIN_W: lowest-index set bit of oht.
- vld, output, 1: at least one bit of oht was set.
- multi, output, 1: two or more bits of oht were set. Present only when the macro is defined.
- out_id, output, ID_W: in_id of the same transaction.

## Operation
- Reduction tree:
  - Level k combines groups of 4 sub-results (valid, index) into one result.
  - The selected index is that of the lowest-numbered valid child; the child number is prepended as the 2 MSBs.
  - The level's valid is the OR of its children's valid bits.
- If BIN_W is odd, level 0 is radix-2. Example: N_WAYS=512 gives levels of 2,4,4,4,4.
- Priority is strict lowest-index-wins. The one-hot assumption is removed, so any input pattern gives a defined result.
- If oht is all zero: vld=0 and bin=0.
- Each level ends in a register slice holding its valid flag, the partial results, the ID, and the multi partials.
- Multi-hit per level:
  - Set if any child's multi is set, or if two or more children are valid.
  - At the leaves, multi is set if two or more of the 4 bits are set.
- Handshake per stage: ready_k = !valid_k | ready_{k+1}; ready_LEVELS = out_ready.
  - A transfer occurs on valid & ready at each boundary.
  - in_ready = ready_0.
- No reordering, dropping or duplication. Results leave in acceptance order.
- Once out_valid is asserted, bin, vld, multi and out_id hold stable until out_ready is sampled high.

## Timing
- Latency is LEVELS cycles from an accepted input to out_valid, with no stall. N_WAYS=1024 gives 5.
- Throughput is 1 per cycle when out_ready stays high.
- While out_ready is low, the pipeline fills. in_ready falls in the cycle when every stage is occupied, so the pipeline holds at most LEVELS entries.
- A simultaneous out_ready rise and in_valid: the pipeline advances and the new entry is accepted in the same cycle.
- Reset value of every output and stage register is 0:
  - out_valid=0, bin=0, vld=0, multi=0, out_id=0.
  - in_ready=1 from the first clock edge after reset deasserts.
- rst asserted mid-operation clears all stages immediately. In-flight transactions are discarded and are not replayed.
- No combinational path from oht to any output. The only combinational path from out_ready is to in_ready.

## Configuration
- TAG_MATCH_MULTIHIT_EN defined:
  - The multi port and its per-stage registers exist.
  - Multi-hit is reported alongside the priority result.
- TAG_MATCH_MULTIHIT_EN undefined:
  - The multi port is absent and no multi logic is generated.
  - All other behaviour and latency are identical.

## Structure
- Package tag_match_pkg holds:
  - constant TM_RADIX=4
  - function tm_levels(n), returning the level count
  - typedef of the per-node result struct {valid, multi, index}, width-parameterised via a localparam chain.
- Sub-module tag_match_pe4_stage: one radix-4 (or radix-2) combine plus its handshake register slice. It is instantiated LEVELS times with generate loops.
- The top module only sizes the levels, chains the ready/valid signals, and drives the output ports.

## Test plan
- N_WAYS=1024, oht bit 700 set, in_id=3, out_ready=1 → 5 cycles later: out_valid=1, bin=700, vld=1, multi=0, out_id=3.
- oht bits 5 and 900 set → bin=5, vld=1, multi=1. With the macro undefined, bin=5 and no multi port exists.
- oht all zero → out_valid=1, vld=0, bin=0, multi=0.
- 8 back-to-back inputs (bits 0..7) with out_ready low for cycles 2-9 → in_ready drops once 5 entries are held. After release, outputs are bin=0..7 in order with no gaps or duplicates.
- rst pulled low while 3 transactions are in flight → out_valid=0 and all outputs 0 asynchronously. After release, in_ready=1 and none of the old results appear.
- N_WAYS=512, bit 511 set → bin=511 after 5 cycles. N_WAYS=16, bits 3 and 12 set → bin=3 after 2 cycles.
